// File: rtl/load_pkg.sv
// ============================================================================
// Module      : load_pkg
// Description : Shared state encoding and address helpers for the load
//               responder blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package load_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } load_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_SHIFT     = $clog2(BYTES_PER_WORD);

   function automatic logic [31:0] byte_swap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with show-ahead read and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int                 c_ptr_w = $clog2(DEPTH);
   localparam logic [c_ptr_w:0]   c_full  = (c_ptr_w + 1)'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w:0]   r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign full      = (r_count == c_full);
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign rdata     = r_mem[r_rd_ptr];
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
            2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: nothing is read until the pointers say so.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= wdata;
   end

endmodule

`default_nettype wire

// File: rtl/bram_load_responder.sv
// ============================================================================
// Module      : bram_load_responder
// Description : Turns word-address load requests into external memory reads
//               and writes the in-order returns into a local BRAM.
//               Optional LOAD_BYTE_SWAP_EN reverses bytes of returned words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_load_responder
   import load_pkg::*;
#(
   parameter int ADDR_W          = 12,
   parameter int REQ_DEPTH       = 8,
   parameter int MAX_OUTSTANDING = 4,
   parameter int DATA_W          = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [23:0]       total_words,
   input  logic [31:0]       base_addr,
   input  logic              req,
   input  logic [31:0]       req_addr,
   output logic              mem_rd_valid,
   output logic [31:0]       mem_rd_addr,
   input  logic              mem_rd_ready,
   input  logic              mem_rdata_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_wdata,
   output logic              addr_valid,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   load_state_t       r_state;
   load_state_t       w_state_nxt;
   logic [23:0]       r_total;
   logic [23:0]       r_written;
   logic [31:0]       r_base;
   logic              r_overflow;
   logic              r_bram_we;
   logic [ADDR_W-1:0] r_bram_addr;
   logic [DATA_W-1:0] r_bram_wdata;

   logic                           w_active;
   logic                           w_req_push;
   logic                           w_req_full;
   logic                           w_req_empty;
   logic [31:0]                    w_req_head;
   logic [$clog2(REQ_DEPTH):0]     w_req_count;
   logic                           w_inf_push;
   logic                           w_inf_pop;
   logic                           w_inf_full;
   logic                           w_inf_empty;
   logic [ADDR_W-1:0]              w_inf_head;
   logic [$clog2(MAX_OUTSTANDING):0] w_inf_count;
   logic                           w_rd_valid;
   logic                           w_issue;
   logic                           w_bypass;
   logic                           w_ret_ok;
   logic [ADDR_W-1:0]              w_ret_addr;
   logic [DATA_W-1:0]              w_wdata;
   logic                           w_drop;

   assign w_active   = (r_state == ST_FILL) || (r_state == ST_DRAIN);
   assign w_req_push = req && w_active && !w_req_full && !start;
   assign w_drop     = req && w_active && w_req_full && !start;

   // In-flight FIFO full is exactly the outstanding-read limit.
   assign w_rd_valid = (w_req_count != '0) && !w_inf_full && !start;
   assign w_issue    = w_rd_valid && mem_rd_ready;

   // A return in the same cycle as the only issue bypasses the in-flight FIFO.
   assign w_bypass   = w_issue && w_inf_empty && mem_rdata_valid;
   assign w_ret_ok   = mem_rdata_valid && !start && (!w_inf_empty || w_issue);
   assign w_ret_addr = w_inf_empty ? w_req_head[ADDR_W-1:0] : w_inf_head;
   assign w_inf_push = w_issue && !w_bypass;
   assign w_inf_pop  = mem_rdata_valid && !w_inf_empty && !start;

`ifdef LOAD_BYTE_SWAP_EN
   assign w_wdata = DATA_W'(byte_swap32(32'(mem_rdata)));
`else
   assign w_wdata = mem_rdata;
`endif

   sync_fifo #(.WIDTH(32), .DEPTH(REQ_DEPTH)) u_req_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start),
      .push  (w_req_push),
      .wdata (req_addr),
      .pop   (w_issue),
      .rdata (w_req_head),
      .full  (w_req_full),
      .empty (w_req_empty),
      .count (w_req_count)
   );

   sync_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTSTANDING)) u_inflight_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start),
      .push  (w_inf_push),
      .wdata (w_req_head[ADDR_W-1:0]),
      .pop   (w_inf_pop),
      .rdata (w_inf_head),
      .full  (w_inf_full),
      .empty (w_inf_empty),
      .count (w_inf_count)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (start) begin
         w_state_nxt = (total_words == '0) ? ST_DONE : ST_FILL;
      end else begin
         case (r_state)
            ST_FILL: begin
               if (r_written == r_total)
                  w_state_nxt = ST_DONE;
               else if (!req && w_req_empty && (w_inf_count != '0))
                  w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
               if (r_written == r_total) w_state_nxt = ST_DONE;
               else if (req)             w_state_nxt = ST_FILL;
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_total      <= '0;
         r_written    <= '0;
         r_base       <= '0;
         r_overflow   <= 1'b0;
         r_bram_we    <= 1'b0;
         r_bram_addr  <= '0;
         r_bram_wdata <= '0;
      end else begin
         r_bram_we <= w_ret_ok;
         if (w_ret_ok) begin
            r_bram_addr  <= w_ret_addr;
            r_bram_wdata <= w_wdata;
         end
         if (start) begin
            r_total    <= total_words;
            r_base     <= base_addr;
            r_written  <= '0;
            r_overflow <= 1'b0;
         end else begin
            if (w_ret_ok) r_written  <= r_written + 24'd1;
            if (w_drop)   r_overflow <= 1'b1;
         end
      end
   end

   assign mem_rd_valid = w_rd_valid;
   assign mem_rd_addr  = w_rd_valid ? (r_base + (w_req_head << WORD_SHIFT)) : '0;
   assign bram_we      = r_bram_we;
   assign bram_addr    = r_bram_addr;
   assign bram_wdata   = r_bram_wdata;
   assign addr_valid   = r_bram_we;
   assign busy         = w_active;
   assign done         = (r_state == ST_DONE);
   assign overflow     = r_overflow;

endmodule

`default_nettype wire

// File: doc/bram_load_responder.md
Name: bram_load_responder

Overview:
- Responder side of the control unit's load-request interface.
- Accepts one word-address request per cycle (`req`/`req_addr`), translates each to a byte-addressed external memory read, and writes the in-order returned data into the local IFM or weight BRAM.
- Pulses `addr_valid` per completed BRAM write and raises `done` once the expected word count is written.
- One instance per buffer: IFM and Weight.

Parameters:
- ADDR_W, 12, BRAM word-address width.
- REQ_DEPTH, 8, pending-request FIFO depth (power of 2).
- MAX_OUTSTANDING, 4, maximum issued-but-unreturned memory reads.
- DATA_W, 32, word width.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle pulse: latch `total_words`, clear counters
- total_words  input  24  words expected for this load
- base_addr  input  32  external byte base address
- req  input  1  load request; may be high every cycle, no backpressure
- req_addr  input  32  word address of request
- mem_rd_valid  output  1  memory read command valid
- mem_rd_addr  output  32  byte address = base_addr + (req_addr << 2)
- mem_rd_ready  input  1  memory accepts command
- mem_rdata_valid  input  1  read data return, in order
- mem_rdata  input  DATA_W  returned data
- bram_we  output  1  BRAM write enable
- bram_addr  output  ADDR_W  BRAM word address = req_addr[ADDR_W-1:0]
- bram_wdata  output  DATA_W  BRAM write data
- addr_valid  output  1  one-cycle pulse per BRAM word written
- busy  output  1  state is FILL or DRAIN
- done  output  1  level; all expected words written
- overflow  output  1  sticky; request dropped on full FIFO

Behaviour:
- Reset (synchronous, rst_n=0 at posedge): every output 0, FIFOs empty, counters 0, state IDLE. Reset mid-load discards all in-flight data; late `mem_rdata_valid` is ignored until the next `start`.
- States:
  - IDLE: `start` -> FILL.
  - FILL: when written_cnt == total_words -> DONE; when `req` is low with the request FIFO empty and outstanding > 0 -> DRAIN.
  - DRAIN: `req` high -> FILL; written_cnt == total_words -> DONE.
  - DONE: `done`=1; `start` -> FILL.
- `start` with total_words=0 goes directly to DONE next cycle.
- Request FIFO:
  - Push {req_addr} when `req`=1 in FILL or DRAIN.
  - Full: request dropped, `overflow` set, sticky until `start` or reset.
  - `req` in IDLE or DONE is ignored and not flagged.
- Issue:
  - `mem_rd_valid` = FIFO not empty AND outstanding < MAX_OUTSTANDING.
  - On valid & ready: pop the request FIFO, push its addr into the in-flight address FIFO (depth MAX_OUTSTANDING), outstanding++.
  - `mem_rd_addr` is combinational from the FIFO head and must hold stable while valid & !ready.
- Return:
  - On `mem_rdata_valid`: pop the in-flight FIFO; next cycle register `bram_we`=1, `bram_addr`, `bram_wdata`, `addr_valid`=1; outstanding--; written_cnt++.
  - Latency from return to BRAM write: exactly 1 cycle.
- Same-cycle issue and return: outstanding unchanged.
- `mem_rdata_valid` with the in-flight FIFO empty: ignored, nothing written.
- Minimum request-to-write latency: 3 cycles (FIFO push, issue with ready=1 and same-cycle return, register). Sustained throughput: 1 word/cycle.
- Arithmetic:
  - written_cnt is 24-bit, compared by equality.
  - Byte address wraps modulo 2^32.
  - `req_addr` bits above ADDR_W are ignored for `bram_addr`.
- A second `start` while busy behaves as reset of counters and FIFOs, followed by FILL.

Optional Feature:
- LOAD_BYTE_SWAP_EN
  - Defined: `bram_wdata` is `mem_rdata` with byte order reversed per 32-bit word (byte0<->byte3, byte1<->byte2). Valid only with DATA_W=32.
  - Undefined: data passes unmodified. Timing and ports identical in both cases.

Decomposition:
- Shared package `load_pkg`: state encoding (IDLE=2'd0, FILL=2'd1, DRAIN=2'd2, DONE=2'd3), BYTES_PER_WORD=4, WORD_SHIFT=2.
- Sub-module `sync_fifo` (params WIDTH, DEPTH; push, pop, full, empty, count) instantiated twice: request FIFO and in-flight address FIFO.

Test Plan:
- start, total_words=4, base_addr=0x1000; req with req_addr 0..3 on consecutive cycles; mem_rd_ready=1; data returned 1 cycle later -> mem_rd_addr 0x1000, 0x1004, 0x1008, 0x100C; BRAM addr 0..3 written in order; 4 addr_valid pulses; done=1 after the 4th write.
- mem_rd_ready held 0 for 10 cycles during 12 back-to-back reqs -> overflow=1; exactly 8 reads are later issued and 8 words written; done stays 0 with total_words=12.
- Data return delayed 6 cycles -> never more than 4 outstanding (mem_rd_valid drops); all 16 words written in address order.
- start with total_words=0 -> done=1 next cycle; no mem_rd_valid.
- rst_n=0 for 1 cycle after 2 of 4 reads are issued -> all outputs 0; the 2 late returns cause no bram_we; a new start then completes normally.
- LOAD_BYTE_SWAP_EN defined, mem_rdata=0x11223344 -> bram_wdata=0x44332211; undefined -> 0x11223344.
